load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface. It sits between the execute stage and the data memory block and accepts one load, store or pass-through request at a time over a valid/ready handshake. It sequences each request into the memory control signals (address, write data, read/write, enable, result-mux select), captures the returned result, and presents it to register writeback as a one-cycle pulse.

## Interface
Parameters:
- none; address and data are fixed at 8 bits, destination register index at 3 bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  2  00 pass-through, 01 load, 10 store, 11 no-op.
- req_addr  in  8  memory address, or ALU result for pass-through.
- req_wdata  in  8  store data.
- req_rd  in  3  destination register index.
- ans_ex  out  8  address/ALU result to the data memory.
- DM_data  out  8  write data to the data memory.
- mem_rw_ex  out  1  1 = write, 0 = read.
- mem_en_ex  out  1  memory access enable.
- mem_mux_sel_dm  out  1  1 = memory read data on ans_dm, 0 = ans_ex on ans_dm.
- ans_dm  in  8  result returned by the data memory block.
- wb_valid  out  1  writeback pulse.
- wb_rd  out  3  writeback register index.
- wb_data  out  8  writeback data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- req_ready = 1 only in IDLE with reset deasserted.
- A request is accepted on a rising edge where req_valid && req_ready. On acceptance, the unit registers ans_ex = req_addr, DM_data = req_wdata, the op and rd.
- Store: IDLE -> ISSUE (mem_en_ex=1, mem_rw_ex=1, mem_mux_sel_dm=0) -> IDLE. The memory writes at the end of ISSUE. A store produces no writeback.
- Load: IDLE -> ISSUE (en=1, rw=0, mux=1) -> WAIT (en=0, mux=1; ans_dm captured at end of WAIT) -> RESP.
- Pass-through: IDLE -> ISSUE (en=0, mux=0; ans_dm captured at end of ISSUE) -> RESP.
- No-op: IDLE -> IDLE. The request is consumed with no memory activity and no writeback.
- RESP: wb_valid=1 for exactly one cycle, then the FSM goes to IDLE. wb_rd and wb_data hold their values until the next RESP.
- Outside ISSUE and WAIT, mem_en_ex, mem_rw_ex and mem_mux_sel_dm are 0. ans_ex and DM_data hold the last accepted values.
- Reset values: state IDLE, req_ready 0 while reset is high and 1 after release. ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm, wb_valid, wb_rd and wb_data are all 0.
- Reset mid-operation aborts the request immediately and asynchronously:
  - enable drops at once, so a store aborted before its ISSUE edge does not write;
  - no writeback is produced.
- req_valid while not ready is ignored. The requester must hold the request stable until it is accepted.

## Timing
- Acceptance edge = edge 0.
- Store: en/rw high in cycle 1; req_ready high again in cycle 2 (next request accepted at edge 2).
- Load: wb_valid high in cycle 3. Next acceptance is possible at edge 4.
- Pass-through: wb_valid high in cycle 2.
- No-op: req_ready stays high; back-to-back acceptance is possible every cycle.
- All outputs except req_ready are registered. req_ready is decoded from the state and reset.

## Configuration
- LSU_FWD_EN defined: adds a last-store register (fwd_valid, fwd_addr, fwd_data).
  - The register is loaded on every store acceptance and cleared by reset.
  - A load whose req_addr equals fwd_addr with fwd_valid=1 skips ISSUE/WAIT and goes IDLE -> RESP. In that case wb_data = fwd_data, wb_valid is high in cycle 1, and mem_en_ex stays 0.
  - A load that misses behaves as without the macro.
- LSU_FWD_EN undefined: every load accesses memory, with 3-cycle latency.

## Test plan
- Reset with reset=1, then release: all outputs 0 during reset; req_ready=1 after release.
- Store op=10, addr=0x03, wdata=0xFF: ans_ex=0x03, DM_data=0xFF, en=1 and rw=1 for exactly cycle 1; no wb_valid; req_ready=1 in cycle 2.
- Load op=01, addr=0x03, rd=5, with the memory model returning 0xFF: en=1, rw=0, mux=1 in cycle 1; mux=1 in cycle 2; wb_valid=1, wb_rd=5, wb_data=0xFF in cycle 3.
- Pass-through op=00, addr=0x3C, rd=2: mux=0, en=0; wb_valid=1, wb_data=0x3C in cycle 2.
- Reset asserted during ISSUE of a store to 0x10 with data 0xAA: en drops immediately, a subsequent load of 0x10 returns the old contents, and no wb_valid pulse occurs.
- With LSU_FWD_EN: store 0x44 to 0x07, then load 0x07 -> wb_data=0x44 in cycle 1 with en never asserted. A load from 0x08 takes the normal 3-cycle memory path.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: sequences load/store/pass-through requests, pulses writeback
// Optional store-to-load forwarding: define LSU_FWD_EN.
module load_store_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [2:0] req_rd,
  output logic [7:0] ans_ex,
  output logic [7:0] DM_data,
  output logic       mem_rw_ex,
  output logic       mem_en_ex,
  output logic       mem_mux_sel_dm,
  input  logic [7:0] ans_dm,
  output logic       wb_valid,
  output logic [2:0] wb_rd,
  output logic [7:0] wb_data
);

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] rd_q, rd_d;
  logic [7:0] ans_ex_q, ans_ex_d;
  logic [7:0] dm_data_q, dm_data_d;
  logic       en_q, en_d;
  logic       rw_q, rw_d;
  logic       mux_q, mux_d;
  logic       wb_valid_q, wb_valid_d;
  logic [2:0] wb_rd_q, wb_rd_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic       accept;

`ifdef LSU_FWD_EN
  logic       fwd_valid_q, fwd_valid_d;
  logic [7:0] fwd_addr_q, fwd_addr_d;
  logic [7:0] fwd_data_q, fwd_data_d;
  logic       fwd_hit;

  assign fwd_hit = fwd_valid_q && (fwd_addr_q == req_addr);
`endif

  // Ready is decoded so that it is low for the whole time reset is held.
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Next-state and registered-output decode; memory controls are computed one
  // cycle ahead so they are valid for the whole ISSUE/WAIT cycle.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    ans_ex_d   = ans_ex_q;
    dm_data_d  = dm_data_q;
    en_d       = 1'b0;
    rw_d       = 1'b0;
    mux_d      = 1'b0;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
`ifdef LSU_FWD_EN
    fwd_valid_d = fwd_valid_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ans_ex_d  = req_addr;
          dm_data_d = req_wdata;
          op_d      = req_op;
          rd_d      = req_rd;
          case (req_op)
            OP_STORE: begin
              state_d = S_ISSUE;
              en_d    = 1'b1;
              rw_d    = 1'b1;
`ifdef LSU_FWD_EN
              fwd_valid_d = 1'b1;
              fwd_addr_d  = req_addr;
              fwd_data_d  = req_wdata;
`endif
            end
            OP_LOAD: begin
`ifdef LSU_FWD_EN
              if (fwd_hit) begin
                state_d    = S_RESP;
                wb_valid_d = 1'b1;
                wb_rd_d    = req_rd;
                wb_data_d  = fwd_data_q;
              end else begin
                state_d = S_ISSUE;
                en_d    = 1'b1;
                mux_d   = 1'b1;
              end
`else
              state_d = S_ISSUE;
              en_d    = 1'b1;
              mux_d   = 1'b1;
`endif
            end
            OP_PASS: state_d = S_ISSUE;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_ISSUE: begin
        if (op_q == OP_LOAD) begin
          state_d = S_WAIT;
          mux_d   = 1'b1;
        end else if (op_q == OP_PASS) begin
          state_d    = S_RESP;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = ans_dm;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        state_d    = S_RESP;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = ans_dm;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; async reset aborts any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      rd_q       <= 3'd0;
      ans_ex_q   <= 8'd0;
      dm_data_q  <= 8'd0;
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      mux_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 3'd0;
      wb_data_q  <= 8'd0;
`ifdef LSU_FWD_EN
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= 8'd0;
      fwd_data_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      ans_ex_q   <= ans_ex_d;
      dm_data_q  <= dm_data_d;
      en_q       <= en_d;
      rw_q       <= rw_d;
      mux_q      <= mux_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
`ifdef LSU_FWD_EN
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
`endif
    end
  end

  assign ans_ex         = ans_ex_q;
  assign DM_data        = dm_data_q;
  assign mem_en_ex      = en_q;
  assign mem_rw_ex      = rw_q;
  assign mem_mux_sel_dm = mux_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a small data-memory model
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [2:0] req_rd;
  logic [7:0] ans_ex;
  logic [7:0] DM_data;
  logic       mem_rw_ex;
  logic       mem_en_ex;
  logic       mem_mux_sel_dm;
  logic [7:0] ans_dm;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
  } wb_t;
  wb_t exp_q[$];

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .ans_ex(ans_ex), .DM_data(DM_data), .mem_rw_ex(mem_rw_ex),
    .mem_en_ex(mem_en_ex), .mem_mux_sel_dm(mem_mux_sel_dm), .ans_dm(ans_dm),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Data memory: unwritten locations read as addr ^ 0x5A; registered read.
  logic [7:0] mem [256];
  logic       written [256];
  logic [7:0] rdata = 8'd0;
  always @(posedge clk) begin
    if (mem_en_ex && mem_rw_ex) begin
      mem[ans_ex]     <= DM_data;
      written[ans_ex] <= 1'b1;
    end
    if (mem_en_ex && !mem_rw_ex)
      rdata <= (written[ans_ex] === 1'b1) ? mem[ans_ex] : (ans_ex ^ 8'h5A);
  end
  assign ans_dm = mem_mux_sel_dm ? rdata : ans_ex;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback monitor: every pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wb: got rd=%0d data=%0h expected no writeback", wb_rd, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {5'd0, wb_rd}, {5'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                       input logic [2:0] rd);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_rd    = rd;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) chk("accept_timeout", {7'd0, req_ready}, 8'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b11;
    req_addr = 8'd0; req_wdata = 8'd0; req_rd = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {7'd0, req_ready}, 8'd0);
    chk("rst_ans_ex", ans_ex, 8'd0);
    chk("rst_dm_data", DM_data, 8'd0);
    chk("rst_ctrl", {5'd0, mem_en_ex, mem_rw_ex, mem_mux_sel_dm}, 8'd0);
    chk("rst_wb", {4'd0, wb_valid, wb_rd}, 8'd0);
    chk("rst_wb_data", wb_data, 8'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", {7'd0, req_ready}, 8'd1);

    // Store 0xFF to 0x03
    issue(2'b10, 8'h03, 8'hFF, 3'd0);
    @(negedge clk);
    chk("st_c1_en_rw_mux", {5'd0, mem_en_ex, mem_rw_ex, mem_mux_sel_dm}, 8'b110);
    chk("st_c1_ans_ex", ans_ex, 8'h03);
    chk("st_c1_dm_data", DM_data, 8'hFF);
    chk("st_c1_ready", {7'd0, req_ready}, 8'd0);
    @(negedge clk);
    chk("st_c2_en_rw", {6'd0, mem_en_ex, mem_rw_ex}, 8'd0);
    chk("st_c2_ready", {7'd0, req_ready}, 8'd1);
    chk("st_c2_ans_ex_hold", ans_ex, 8'h03);

    // Load 0x03 -> rd 5
    exp_q.push_back('{rd: 3'd5, data: 8'hFF});
    issue(2'b01, 8'h03, 8'h00, 3'd5);
    @(negedge clk);
    chk("ld_c1_en_rw_mux", {5'd0, mem_en_ex, mem_rw_ex, mem_mux_sel_dm}, 8'b101);
    @(negedge clk);
    chk("ld_c2_en_mux", {5'd0, mem_en_ex, mem_rw_ex, mem_mux_sel_dm}, 8'b001);
    chk("ld_c2_wb_valid", {7'd0, wb_valid}, 8'd0);
    @(negedge clk);
    chk("ld_c3_wb_valid", {7'd0, wb_valid}, 8'd1);
    @(negedge clk);
    chk("ld_c4_ready", {7'd0, req_ready}, 8'd1);
    chk("ld_c4_wb_valid", {7'd0, wb_valid}, 8'd0);
    chk("ld_c4_wb_data_hold", wb_data, 8'hFF);

    // Pass-through 0x3C -> rd 2
    exp_q.push_back('{rd: 3'd2, data: 8'h3C});
    issue(2'b00, 8'h3C, 8'h00, 3'd2);
    @(negedge clk);
    chk("pt_c1_en_mux", {6'd0, mem_en_ex, mem_mux_sel_dm}, 8'd0);
    @(negedge clk);
    chk("pt_c2_wb_valid", {7'd0, wb_valid}, 8'd1);
    @(negedge clk);
    chk("pt_c3_ready", {7'd0, req_ready}, 8'd1);

    // No-op: consumed without memory activity, ready stays high
    issue(2'b11, 8'h55, 8'h00, 3'd7);
    @(negedge clk);
    chk("nop_c1_ready", {7'd0, req_ready}, 8'd1);
    chk("nop_c1_en", {7'd0, mem_en_ex}, 8'd0);
    issue(2'b11, 8'h66, 8'h00, 3'd6);
    @(negedge clk);
    chk("nop2_c1_ready", {7'd0, req_ready}, 8'd1);

    // Reset during ISSUE of a store to 0x10
    issue(2'b10, 8'h10, 8'hAA, 3'd0);
    @(negedge clk);
    chk("ab_c1_en", {7'd0, mem_en_ex}, 8'd1);
    reset = 1'b1;
    #1;
    chk("ab_en_drop", {7'd0, mem_en_ex}, 8'd0);
    chk("ab_ready", {7'd0, req_ready}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back('{rd: 3'd1, data: 8'h4A});
    issue(2'b01, 8'h10, 8'h00, 3'd1);
    repeat (4) @(negedge clk);

    // Store 0x44 to 0x07, then load 0x07 and 0x08
    issue(2'b10, 8'h07, 8'h44, 3'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back('{rd: 3'd3, data: 8'h44});
    issue(2'b01, 8'h07, 8'h00, 3'd3);
    @(negedge clk);
`ifdef LSU_FWD_EN
    chk("fwd_c1_wb_valid", {7'd0, wb_valid}, 8'd1);
    chk("fwd_c1_en", {7'd0, mem_en_ex}, 8'd0);
    @(negedge clk);
    chk("fwd_c2_ready", {7'd0, req_ready}, 8'd1);
    chk("fwd_c2_en", {7'd0, mem_en_ex}, 8'd0);
`else
    chk("ld7_c1_en", {7'd0, mem_en_ex}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    chk("ld7_c3_wb_valid", {7'd0, wb_valid}, 8'd1);
    @(negedge clk);
`endif
    exp_q.push_back('{rd: 3'd4, data: 8'h52});
    issue(2'b01, 8'h08, 8'h00, 3'd4);
    @(negedge clk);
    chk("ld8_c1_en_mux", {6'd0, mem_en_ex, mem_mux_sel_dm}, 8'b11);
    @(negedge clk);
    chk("ld8_c2_wb_valid", {7'd0, wb_valid}, 8'd0);
    @(negedge clk);
    chk("ld8_c3_wb_valid", {7'd0, wb_valid}, 8'd1);
    repeat (4) @(negedge clk);

    chk("pending_wb", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
